pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Sequential partner of the combinational next-PC logic: holds the architectural PC, fetches the instruction at PC from instruction memory over a request/response handshake, and presents {pc, inst} to decode.
- On decode accept, it loads the next PC from the next-PC logic, which is computed from pc_out/inst.
- Supports a one-shot redirect (exception/flush) that overrides the next PC and kills an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; bits [1:0] are the word-alignment bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- npc  in  32  next PC from next-PC logic, sampled on decode accept
- redirect  in  1  flush and load redirect_pc (single-cycle pulse)
- redirect_pc  in  32  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address (= pc)
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  response valid (at most one per granted request)
- imem_rdata  in  32  response instruction word
- pc_out  out  32  PC of the presented instruction
- inst_out  out  32  presented instruction
- inst_valid  out  1  {pc_out, inst_out} valid
- id_ready  in  1  decode accepts when inst_valid & id_ready
- exc_adel  out  1  presented entry is a misaligned fetch (inst_out = 0)

Behaviour:
- Reset (async, immediate): pc = RESET_PC, state = REQ, imem_req = 0 in the reset cycle, inst_valid = 0, inst_out = 0, pc_out = RESET_PC, exc_adel = 0, kill = 0.
- States: REQ, WAIT, HOLD.
- REQ:
  - If pc[1:0] != 0: no request; go to HOLD with inst_out = 0, exc_adel = 1, inst_valid = 1.
  - Else imem_req = 1, imem_addr = pc, held stable until imem_gnt. On gnt, go to WAIT.
- WAIT: imem_req = 0. On imem_rvalid:
  - If kill = 0: latch inst_out = imem_rdata, pc_out = pc, inst_valid = 1, go to HOLD.
  - If kill = 1: drop the data, clear kill, go to REQ.
- HOLD: outputs stable while id_ready = 0. On inst_valid & id_ready: pc <= npc, inst_valid <= 0, exc_adel <= 0, go to REQ next cycle.
- Latency:
  - Minimum accept-to-next-inst_valid is 3 cycles (REQ with gnt same cycle, WAIT with rvalid the next cycle, HOLD).
  - Zero-wait memory therefore gives one instruction per 3 cycles.
- Redirect has priority over everything in all states. It sets pc <= redirect_pc and inst_valid <= 0, with no accept even if id_ready = 1 in that cycle.
  - REQ, gnt not asserted: the request is withdrawn and the new pc is requested next cycle.
  - REQ, gnt in the same cycle: kill <= 1, go to WAIT.
  - WAIT: kill <= 1, stay in WAIT until rvalid, then go to REQ.
  - WAIT with rvalid in the same cycle: the data is dropped, go to REQ.
  - HOLD: go to REQ.
- The redirect target is itself subject to the misalignment check in REQ.
- npc is not checked by this block except via REQ misalignment; the full 32 bits are loaded, with no wrap handling (PC arithmetic is owned by the next-PC logic).
- imem_rvalid outside WAIT is ignored.
- pc_out always reflects the PC of the currently presented or last presented entry. The internal pc is the fetch address.

Test Plan:
- Reset then zero-wait memory (gnt = 1 in REQ, rvalid the following cycle, rdata = 32'h2408_0005), id_ready = 1, npc = pc + 4 -> imem_addr = 0x3000, 0x3004, 0x3008 on successive requests. inst_valid pulses every 3rd cycle with pc_out matching.
- id_ready low for 4 cycles in HOLD -> pc_out, inst_out and inst_valid stable. No imem_req until accept, then next address = npc.
- Redirect (redirect_pc = 0x4180) while in WAIT, rvalid arrives 2 cycles later with 0xDEADBEEF -> data never presented. Next imem_addr = 0x4180, and its data is presented with pc_out = 0x4180.
- Redirect coincident with accept in HOLD (npc = 0x3010, redirect_pc = 0x4180) -> next imem_addr = 0x4180, not 0x3010.
- npc = 0x3006 accepted -> no imem_req. inst_valid = 1, exc_adel = 1, inst_out = 0, pc_out = 0x3006. After a redirect to 0x4180, normal fetch resumes.
- Assert rst mid-WAIT -> outputs return to reset values immediately. The stale rvalid is ignored and the first request after reset is 0x3000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch stage register: holds the architectural PC, fetches over a req/gnt/rvalid
// handshake and presents {pc, inst} to decode, with a one-shot redirect/flush.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] npc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       inst_out,
  output logic              inst_valid,
  input  logic              id_ready,
  output logic              exc_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t            r_state, w_nstate;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic              r_kill, w_kill;
  logic [ADDR_W-1:0] r_pc_out, w_pc_out;
  logic [31:0]       r_inst_out, w_inst_out;
  logic              r_inst_valid, w_inst_valid;
  logic              r_exc_adel, w_exc_adel;
  logic              w_misal;

  assign w_misal = |r_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_pc_out     <= RESET_PC;
      r_inst_out   <= 32'h0;
      r_inst_valid <= 1'b0;
      r_exc_adel   <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_pc         <= w_pc;
      r_kill       <= w_kill;
      r_pc_out     <= w_pc_out;
      r_inst_out   <= w_inst_out;
      r_inst_valid <= w_inst_valid;
      r_exc_adel   <= w_exc_adel;
    end
  end

  always_comb begin
    w_nstate     = r_state;
    w_pc         = r_pc;
    w_kill       = r_kill;
    w_pc_out     = r_pc_out;
    w_inst_out   = r_inst_out;
    w_inst_valid = r_inst_valid;
    w_exc_adel   = r_exc_adel;
    if (redirect) begin
      // Redirect wins over accept; a granted or outstanding fetch is marked dead.
      w_pc         = redirect_pc;
      w_inst_valid = 1'b0;
      w_exc_adel   = 1'b0;
      case (r_state)
        S_REQ: begin
          if (!w_misal && imem_gnt) begin
            w_nstate = S_WAIT;
            w_kill   = 1'b1;
          end else begin
            w_nstate = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_nstate = S_REQ;
            w_kill   = 1'b0;
          end else begin
            w_kill   = 1'b1;
          end
        end
        default: w_nstate = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_misal) begin
            w_nstate     = S_HOLD;
            w_inst_out   = 32'h0;
            w_exc_adel   = 1'b1;
            w_inst_valid = 1'b1;
            w_pc_out     = r_pc;
          end else if (imem_gnt) begin
            w_nstate = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              w_kill   = 1'b0;
              w_nstate = S_REQ;
            end else begin
              w_inst_out   = imem_rdata;
              w_pc_out     = r_pc;
              w_inst_valid = 1'b1;
              w_nstate     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (r_inst_valid && id_ready) begin
            w_pc         = npc;
            w_inst_valid = 1'b0;
            w_exc_adel   = 1'b0;
            w_nstate     = S_REQ;
          end
        end
        default: w_nstate = S_REQ;
      endcase
    end
  end

  // Request is held off while reset is asserted so nothing leaks out in that cycle.
  assign imem_req   = (r_state == S_REQ) && !w_misal && !rst;
  assign imem_addr  = r_pc;
  assign pc_out     = r_pc_out;
  assign inst_out   = r_inst_out;
  assign inst_valid = r_inst_valid;
  assign exc_adel   = r_exc_adel;

endmodule
